alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute stage: single-cycle logic/arithmetic ops, and
// bit-serial shifts (one bit per cycle), with a valid/ready handshake.
module alu_exec #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_XOR  = 4'b1001;
   localparam logic [3:0] OP_SLL  = 4'b1010;
   localparam logic [3:0] OP_SRL  = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1100;

   logic [1:0]      state;
   logic [XLEN-1:0] result_q;   // doubles as the shift working register
   logic [4:0]      cnt;
   logic [3:0]      ctrl_q;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] shift_one;
   logic            is_shift;
   logic [4:0]      shamt;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign result    = result_q;
   assign zero      = (result_q == '0);
   assign shamt     = op_b[4:0];
   assign is_shift  = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                      (alu_control == OP_SRA);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      alu_res = '0;
      case (alu_control)
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      shift_one = result_q;
      case (ctrl_q)
         OP_SLL:  shift_one = {result_q[XLEN-2:0], 1'b0};
         OP_SRL:  shift_one = {1'b0, result_q[XLEN-1:1]};
         OP_SRA:  shift_one = {result_q[XLEN-1], result_q[XLEN-1:1]};
         default: shift_one = result_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         result_q <= '0;
         cnt      <= '0;
         ctrl_q   <= OP_AND;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ctrl_q <= alu_control;
                  if (is_shift) begin
                     result_q <= op_a;
                     cnt      <= shamt;
                     state    <= (shamt == 5'd0) ? DONE : SHIFT;
                  end else begin
                     result_q <= alu_res;
                     state    <= DONE;
                  end
               end
            end
            SHIFT: begin
               if (cnt == 5'd0) begin
                  state <= DONE;
               end else begin
                  result_q <= shift_one;
                  cnt      <= cnt - 5'd1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
